if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipeline; producer side of the IF->ID interface.
//  Holds the PC and fetches from instruction memory over a req/ack handshake.
//  Presents a registered instruction, PC+4, valid flag and debug type/number to ID.
//  Honours hazard stalls and branch redirects coming back from ID.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  NOP_INST  32'h0000_0000  instruction word driven on bubbles and after reset
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous reset, active-low (0 = reset)
//  stall          in   1   hazard unit: hold IF outputs and PC
//  br_taken       in   1   ID: redirect fetch this cycle
//  br_target      in   32  ID: redirect address
//  imem_req       out  1   fetch request
//  imem_addr      out  32  fetch address (always = pc)
//  imem_ack       in   1   imem_rdata valid for the imem_addr of this same cycle
//  imem_rdata     in   32  fetched word
//  if_inst        out  32  registered instruction to ID
//  if_pc4         out  32  registered fetch PC + 4
//  if_valid       out  1   if_inst is a real instruction (0 = bubble)
//  IF_ins_type    out  4   debug class of if_inst
//  IF_ins_number  out  4   debug sequence number of if_inst
// BEHAVIOUR
//  Reset (rst=0, async): pc=RESET_PC, state=FETCH, seq=0, hold buffer cleared.
//   Output reset values: imem_req=0, imem_addr=RESET_PC, if_inst=NOP_INST, if_pc4=0,
//   if_valid=0, IF_ins_type=0, IF_ins_number=0. imem_req rises on the first edge after release.
//  FSM: FETCH, HOLD.
//  FETCH: imem_req=1, imem_addr=pc. The request is squashable: memory samples addr each cycle.
//   ack=1 & stall=0: if_inst<=rdata, if_pc4<=pc+4, if_valid<=1, IF_ins_number<=seq,
//     seq<=seq+1, pc<=pc+4. Data appears on outputs the cycle after the ack.
//   ack=1 & stall=1: rdata is captured into the hold buffer; next state HOLD; outputs and pc unchanged.
//   ack=0 & stall=0: bubble. if_valid<=0, if_inst<=NOP_INST, IF_ins_type<=0;
//     if_pc4 and IF_ins_number unchanged.
//   ack=0 & stall=1: all outputs unchanged.
//  HOLD: imem_req=0. While stall=1, everything holds.
//   On stall=0: the held word is delivered exactly as in "ack & !stall"; next state FETCH.
//  br_taken=1 (any state) overrides stall and ack:
//   pc<={br_target[31:2],2'b00}; a same-cycle ack and the hold buffer are discarded;
//   outputs load a bubble (if_valid=0, if_inst=NOP_INST); next state FETCH; seq unchanged.
//  Arithmetic: pc+4 and if_pc4 wrap modulo 2^32; seq wraps 15->0. An instruction fetched
//   at 32'hFFFF_FFFC yields if_pc4=0.
//  IF_ins_type is decoded from the delivered word's op[31:26]:
//   0x00->0 (R), 0x08..0x0F->1 (I-arith), 0x23->2 (lw), 0x2B->3 (sw),
//   0x04/0x05->4 (branch), 0x02->5 (j), others->15.
//  Reset during HOLD or mid-fetch: all state clears immediately. The held word is lost;
//   fetch restarts at RESET_PC.
// TESTING
//  1 Reset then release; ack=1 always, rdata=addr: edges 1..3 deliver if_pc4=4,8,12,
//    if_inst=0,4,8, IF_ins_number=0,1,2, if_valid=1.
//  2 ack delayed 2 cycles per fetch: two bubble cycles (if_valid=0, if_inst=NOP) between
//    valid instructions; pc advances only on ack.
//  3 stall=1 in the same cycle as the ack for pc=8, held 3 cycles: outputs frozen; imem_req=0
//    in HOLD; after stall drops, if_pc4=12 is delivered exactly once with no refetch.
//  4 br_taken with br_target=32'h103 while stall=1 and ack=1: next cycle if_valid=0,
//    imem_addr=32'h100; next delivered if_pc4=32'h104.
//  5 rst=0 asserted while in HOLD: outputs go to reset values without a clock edge;
//    first fetch after release uses RESET_PC.
//  6 Deliver 17 words: lw(0x8C..), sw(0xAC..), beq, j, add, op 0x3F -> types 2,3,4,5,0,15;
//    IF_ins_number sequence wraps 15->0; pc=FFFF_FFFC gives if_pc4=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory port and
// hands a registered instruction, PC+4, valid flag and debug tags to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic [3:0]  IF_ins_type,
    output logic [3:0]  IF_ins_number
);

    // Handshake: imem_ack qualifies imem_rdata for the imem_addr of the same
    // cycle; the request is squashable, so memory re-samples imem_addr each cycle.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_q;
    logic [3:0]  seq;

    logic        deliver;
    logic [31:0] deliver_word;
    logic [31:0] pc_plus4;
    logic [31:0] br_pc;

    function automatic logic [3:0] decode_type(input logic [5:0] op);
        logic [3:0] t;
        t = 4'd15;
        case (op)
            6'h00:                          t = 4'd0;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:     t = 4'd1;
            6'h23:                          t = 4'd2;
            6'h2B:                          t = 4'd3;
            6'h04, 6'h05:                   t = 4'd4;
            6'h02:                          t = 4'd5;
            default:                        t = 4'd15;
        endcase
        return t;
    endfunction

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign br_pc     = br_target & 32'hFFFF_FFFC;

    // A word reaches ID either straight from memory or from the hold buffer
    // once the stall that parked it has cleared.
    always_comb begin
        deliver      = 1'b0;
        deliver_word = imem_rdata;
        if (state == FETCH) begin
            deliver = imem_ack && !stall;
        end else begin
            deliver      = !stall;
            deliver_word = hold_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            hold_q        <= 32'd0;
            seq           <= 4'd0;
            imem_req      <= 1'b0;
            if_inst       <= NOP_INST;
            if_pc4        <= 32'd0;
            if_valid      <= 1'b0;
            IF_ins_type   <= 4'd0;
            IF_ins_number <= 4'd0;
        end else if (br_taken) begin
            // Redirect wins over stall and ack; any captured word is stale.
            state       <= FETCH;
            pc          <= br_pc;
            hold_q      <= 32'd0;
            imem_req    <= 1'b1;
            if_inst     <= NOP_INST;
            if_valid    <= 1'b0;
            IF_ins_type <= 4'd0;
        end else if (deliver) begin
            state         <= FETCH;
            pc            <= pc_plus4;
            imem_req      <= 1'b1;
            if_inst       <= deliver_word;
            if_pc4        <= pc_plus4;
            if_valid      <= 1'b1;
            IF_ins_type   <= decode_type(deliver_word[31:26]);
            IF_ins_number <= seq;
            seq           <= seq + 4'd1;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        hold_q   <= imem_rdata;
                        state    <= HOLD;
                        imem_req <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                        if (!stall) begin
                            if_valid    <= 1'b0;
                            if_inst     <= NOP_INST;
                            IF_ins_type <= 4'd0;
                        end
                    end
                end
                HOLD: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model answers with addr-derived words,
// each scenario checks a packed snapshot of all outputs against hand values.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_inst;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic [3:0]  IF_ins_type;
    logic [3:0]  IF_ins_number;

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = 0;

    logic [105:0] obs;
    logic [105:0] e;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .if_inst(if_inst), .if_pc4(if_pc4), .if_valid(if_valid),
        .IF_ins_type(IF_ins_type), .IF_ins_number(IF_ins_number)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, if_valid, IF_ins_type, IF_ins_number, if_pc4, if_inst, imem_addr};

    // Word table for the decode/wrap scenario, indexed from base FFFF_FFC0.
    function automatic logic [31:0] tab_word(input logic [31:0] addr);
        logic [31:0] k;
        logic [31:0] base [7];
        base = '{32'h8C00_0000, 32'hAC00_0000, 32'h1000_0000, 32'h0800_0000,
                 32'h0000_0020, 32'hFC00_0000, 32'h3000_0000};
        k = (addr - 32'hFFFF_FFC0) >> 2;
        return base[k % 7] | (k << 8);
    endfunction

    always_comb begin
        case (mode)
            1:       imem_rdata = imem_addr + 32'h1000_0000;
            2:       imem_rdata = tab_word(imem_addr);
            default: imem_rdata = imem_addr;
        endcase
    end

    function automatic logic [105:0] mk(input logic req, input logic vld, input logic [3:0] typ,
                                        input logic [3:0] num, input logic [31:0] pc4,
                                        input logic [31:0] inst, input logic [31:0] addr);
        return {req, vld, typ, num, pc4, inst, addr};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0; imem_ack = 1'b0; mode = 0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'd0; imem_ack = 1'b0; mode = 0;
        #2;
        e = mk(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_async got %h exp %h", obs, e); end
        tick(); tick();
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL reset_held got %h exp %h", obs, e); end
        rst = 1'b1;
    endtask

    task automatic test_stream;
        logic [105:0] ev [3];
        do_reset();
        imem_ack = 1'b1;
        ev[0] = mk(1'b1, 1'b1, 4'd0, 4'd0, 32'd4,  32'd0, 32'd4);
        ev[1] = mk(1'b1, 1'b1, 4'd0, 4'd1, 32'd8,  32'd4, 32'd8);
        ev[2] = mk(1'b1, 1'b1, 4'd0, 4'd2, 32'd12, 32'd8, 32'd12);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs !== ev[i]) begin n_bad++; $display("FAIL stream_e%0d got %h exp %h", i + 1, obs, ev[i]); end
        end
    endtask

    task automatic test_ack_delay;
        logic [105:0] ev [6];
        logic         ak [6];
        do_reset();
        mode = 1;
        ak = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ev[0] = mk(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
        ev[1] = mk(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
        ev[2] = mk(1'b1, 1'b1, 4'd4, 4'd0, 32'd4, 32'h1000_0000, 32'd4);
        ev[3] = mk(1'b1, 1'b0, 4'd0, 4'd0, 32'd4, 32'd0, 32'd4);
        ev[4] = mk(1'b1, 1'b0, 4'd0, 4'd0, 32'd4, 32'd0, 32'd4);
        ev[5] = mk(1'b1, 1'b1, 4'd4, 4'd1, 32'd8, 32'h1000_0004, 32'd8);
        for (int i = 0; i < 6; i++) begin
            imem_ack = ak[i];
            tick();
            n_cmp++;
            if (obs !== ev[i]) begin n_bad++; $display("FAIL ack_delay_c%0d got %h exp %h", i, obs, ev[i]); end
        end
    endtask

    task automatic test_stall_hold;
        do_reset();
        imem_ack = 1'b1;
        tick(); tick();
        stall = 1'b1;
        tick();
        // Parked in HOLD; live rdata now differs from the captured word.
        imem_ack = 1'b0; mode = 1;
        e = mk(1'b0, 1'b1, 4'd0, 4'd1, 32'd8, 32'd4, 32'd8);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL stall_frozen_%0d got %h exp %h", i, obs, e); end
            if (i < 2) tick();
        end
        stall = 1'b0;
        tick();
        e = mk(1'b1, 1'b1, 4'd0, 4'd2, 32'd12, 32'd8, 32'd12);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL stall_release got %h exp %h", obs, e); end
        tick();
        e = mk(1'b1, 1'b0, 4'd0, 4'd2, 32'd12, 32'd0, 32'd12);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL stall_no_refetch got %h exp %h", obs, e); end
        mode = 0; imem_ack = 1'b1;
        tick();
        e = mk(1'b1, 1'b1, 4'd0, 4'd3, 32'd16, 32'd12, 32'd16);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL stall_resume got %h exp %h", obs, e); end
    endtask

    task automatic test_branch;
        do_reset();
        imem_ack = 1'b1;
        tick();
        br_taken = 1'b1; br_target = 32'h103; stall = 1'b1;
        tick();
        e = mk(1'b1, 1'b0, 4'd0, 4'd0, 32'd4, 32'd0, 32'h100);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL br_over_stall got %h exp %h", obs, e); end
        br_taken = 1'b0; stall = 1'b0;
        tick();
        e = mk(1'b1, 1'b1, 4'd0, 4'd1, 32'h104, 32'h100, 32'h104);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL br_target_fetch got %h exp %h", obs, e); end
        stall = 1'b1;
        tick();
        br_taken = 1'b1; br_target = 32'h200;
        tick();
        e = mk(1'b1, 1'b0, 4'd0, 4'd1, 32'h104, 32'd0, 32'h200);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL br_in_hold got %h exp %h", obs, e); end
        br_taken = 1'b0; stall = 1'b0;
        tick();
        e = mk(1'b1, 1'b1, 4'd0, 4'd2, 32'h204, 32'h200, 32'h204);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL br_hold_resume got %h exp %h", obs, e); end
    endtask

    task automatic test_reset_in_hold;
        do_reset();
        imem_ack = 1'b1;
        tick(); tick();
        stall = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        #1;
        e = mk(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL rst_in_hold got %h exp %h", obs, e); end
        tick();
        rst = 1'b1; stall = 1'b0;
        tick();
        e = mk(1'b1, 1'b1, 4'd0, 4'd0, 32'd4, 32'd0, 32'd4);
        n_cmp++;
        if (obs !== e) begin n_bad++; $display("FAIL rst_restart got %h exp %h", obs, e); end
    endtask

    task automatic test_decode_wrap;
        logic [3:0]  typ [7];
        logic [31:0] pc4;
        typ = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd15, 4'd1};
        do_reset();
        mode = 2;
        br_taken = 1'b1; br_target = 32'hFFFF_FFC0;
        tick();
        br_taken = 1'b0; imem_ack = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            pc4 = 32'hFFFF_FFC4 + 32'(4 * k);
            e = mk(1'b1, 1'b1, typ[k % 7], 4'(k % 16), pc4,
                   tab_word(32'hFFFF_FFC0 + 32'(4 * k)), pc4);
            n_cmp++;
            if (obs !== e) begin n_bad++; $display("FAIL decode_w%0d got %h exp %h", k, obs, e); end
            if (k == 15) begin
                n_cmp++;
                if (if_pc4 !== 32'd0) begin n_bad++; $display("FAIL pc4_wrap got %h exp 0", if_pc4); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ack_delay();
        test_stall_hold();
        test_branch();
        test_reset_in_hold();
        test_decode_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
